adc_dual_spi_if: RTL and testbench
==================================

Name: adc_dual_spi_if

Overview:
Front-end interface to the dual-channel, simultaneous-sampling serial ADC that digitises the X and Y antenna signals.
- Paces conversions at a fixed sample rate and drives CNV/CS_N/SCLK.
- Shifts both SDO lines in parallel and converts the codes to two's complement.
- Presents xant/yant samples with a one-cycle valid strobe that feeds both signal_path instances (sample_in, sample_clk).

Parameters:
DW, 16, ADC word width and output sample width
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
CONV_CYCLES, 4, clk cycles CNV is held high (conversion time)
SAMPLE_PERIOD, 100, clk cycles between conversion starts
OFFSET_BINARY, 1, 1 = ADC outputs offset binary (invert MSB); 0 = already two's complement

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = free-run conversions; 0 = stop after the current conversion
adc_cnv  out  1  conversion start, high during CONV
adc_cs_n  out  1  chip select, low during SHIFT
adc_sclk  out  1  serial clock, idles low
adc_sdo_x  in  1  X-antenna serial data, MSB first
adc_sdo_y  in  1  Y-antenna serial data, MSB first
xant_sample  out  DW  latest X sample, two's complement
yant_sample  out  DW  latest Y sample, two's complement
sample_valid  out  1  one-cycle strobe, new samples on the outputs
overrun  out  1  sticky: a tick arrived while not IDLE
overrun_clr  in  1  clears overrun

Behaviour:
- Reset values: adc_cnv=0, adc_cs_n=1, adc_sclk=0, xant/yant_sample=0, sample_valid=0, overrun=0, state IDLE, period counter 0.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable=1.
  - tick = (count==SAMPLE_PERIOD-1) && enable.
  - enable=0 holds the counter at 0; first tick comes SAMPLE_PERIOD cycles after enable rises.
- FSM IDLE -> CONV -> SHIFT -> DONE -> IDLE.
  - IDLE: on tick, go to CONV.
  - CONV: adc_cnv=1 for exactly CONV_CYCLES cycles, then go to SHIFT.
  - SHIFT:
    - Lasts 2*CLK_DIV*DW cycles with adc_cs_n=0.
    - Each bit period is CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high.
    - Both SDO lines are captured on the clk edge where sclk goes 0->1, shifting left (MSB first).
  - DONE (1 cycle): adc_cs_n=1, sclk=0.
    - Outputs get the shifted words, with MSB inverted if OFFSET_BINARY.
    - sample_valid=1 this cycle only.
- Latency: tick in cycle T gives sample_valid in cycle T+1+CONV_CYCLES+2*CLK_DIV*DW (defaults: T+69).
  - Outputs hold between strobes.
- Tick while not IDLE: the tick is dropped, overrun is set, and the current conversion is undisturbed.
- overrun_clr together with a new overrun event in the same cycle: set wins.
- enable dropping mid-conversion: the conversion completes, including the DONE strobe. No new tick is generated.
- rst mid-conversion: immediate return to reset values next cycle. Partial shift data is discarded; no strobe.
- Elaboration check: SAMPLE_PERIOD >= CONV_CYCLES+2*CLK_DIV*DW+2, otherwise $error.
- SDO is treated as synchronous to the generated SCLK. The board guarantees setup at CLK_DIV>=2, so no synchroniser is used.

Decomposition:
- Package avy_pkg: typedef enum adc_state_t {IDLE, CONV, SHIFT, DONE}; localparam DW=16 shared with top/signal_path.
- Sub-module sample_tick_gen (period counter + enable gating → tick), reusable for the oscillator's next_sample pacing.
- Shift registers and sclk divider stay inline.

Test Plan:
- Single conversion, defaults:
  - Stimulus: enable=1 after reset; ADC model drives X=0x8123, Y=0x7FFF.
  - Response: first tick at cycle 99, valid at cycle 168.
  - Outputs xant=0x0123, yant=0xFFFF.
  - cnv high 4 cycles; exactly 16 sclk rising edges while cs_n=0.
- Continuous run:
  - Stimulus: 10 conversions with an incrementing ramp 0x8000+n.
  - Response: sample_valid exactly every 100 cycles; xant=n; no overrun.
- OFFSET_BINARY=0:
  - Stimulus: ADC drives 0x8000.
  - Response: xant=0x8000 unchanged.
- Overrun:
  - Stimulus: instance with SAMPLE_PERIOD=70 (minimum legal) runs clean; force a second tick via a test hook during SHIFT.
  - Response: overrun=1, current sample correct, tick dropped.
  - overrun_clr then clears it; simultaneous clr and event leaves it at 1.
- enable drop mid-shift:
  - Stimulus: enable=0 at bit 8 of the shift.
  - Response: conversion finishes, valid pulses once, then no further cnv pulses.
- Reset mid-shift:
  - Stimulus: rst=1 for 1 cycle at bit 5.
  - Response: next cycle cs_n=1, sclk=0, cnv=0, samples=0, no valid.
  - The next conversion starts SAMPLE_PERIOD cycles after reset release.

Source files
------------

// File: rtl/avy_pkg.sv
// Shared definitions for the antenna front end.
//   DW          : default ADC word / sample width, shared with the signal path
//   adc_state_t : conversion sequencer states
package avy_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DONE
  } adc_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate pacing: counts 0..Period-1 while enabled and emits a one-cycle tick on the last
// count. Disabling holds the count at zero, so the first tick lands Period cycles after enable.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   enable_i : run the counter
//   tick_o   : one-cycle pulse when count == Period-1 and enabled
module sample_tick_gen #(
  parameter int unsigned Period = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Period - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == Last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == Last);

endmodule

// File: rtl/adc_dual_spi_if.sv
// Front end for the dual-channel simultaneous-sampling serial ADC (X and Y antennas).
// Paces conversions, drives CNV/CS_N/SCLK, shifts both SDO lines in parallel and presents
// two's-complement samples with a one-cycle valid strobe.
//   clk, rst               : system clock, synchronous active-high reset
//   enable                 : free-run conversions; 0 stops after the current one
//   adc_cnv/adc_cs_n/adc_sclk : ADC control (CNV high in CONV, CS_N low in SHIFT, SCLK idles low)
//   adc_sdo_x/adc_sdo_y    : serial data, MSB first
//   xant_sample/yant_sample: latest samples, two's complement, held between strobes
//   sample_valid           : one-cycle strobe with new samples
//   overrun/overrun_clr    : sticky flag for ticks arriving mid-conversion, and its clear
module adc_dual_spi_if
  import avy_pkg::*;
#(
  parameter int unsigned DW            = avy_pkg::DW,
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CONV_CYCLES   = 4,
  parameter int unsigned SAMPLE_PERIOD = 100,
  parameter int unsigned OFFSET_BINARY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          adc_cnv,
  output logic          adc_cs_n,
  output logic          adc_sclk,
  input  logic          adc_sdo_x,
  input  logic          adc_sdo_y,
  output logic [DW-1:0] xant_sample,
  output logic [DW-1:0] yant_sample,
  output logic          sample_valid,
  output logic          overrun,
  input  logic          overrun_clr
);

  localparam int unsigned ShiftCycles = 2 * CLK_DIV * DW;
  localparam int unsigned CntMax = (ShiftCycles > CONV_CYCLES) ? ShiftCycles : CONV_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam int unsigned HalfW = $clog2(CLK_DIV + 1);

  localparam logic [CntW-1:0]  ConvLast  = CntW'(CONV_CYCLES - 1);
  localparam logic [CntW-1:0]  ShiftLast = CntW'(ShiftCycles - 1);
  localparam logic [HalfW-1:0] HalfLast  = HalfW'(CLK_DIV - 1);
  localparam logic [DW-1:0]    MsbMask   =
      (OFFSET_BINARY != 0) ? {1'b1, {(DW - 1){1'b0}}} : {DW{1'b0}};

  if (SAMPLE_PERIOD < CONV_CYCLES + 2 * CLK_DIV * DW + 2) begin : g_bad_period
    $error("adc_dual_spi_if: SAMPLE_PERIOD too short for one conversion");
  end
  if (CLK_DIV < 1 || CONV_CYCLES < 1) begin : g_bad_timing
    $error("adc_dual_spi_if: CLK_DIV and CONV_CYCLES must be >= 1");
  end

  adc_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HalfW-1:0] half_q, half_d;
  logic             sclk_q, sclk_d;
  logic             cnv_q, cnv_d;
  logic             cs_n_q, cs_n_d;
  logic [DW-1:0]    shx_q, shx_d;
  logic [DW-1:0]    shy_q, shy_d;
  logic [DW-1:0]    xs_q, xs_d;
  logic [DW-1:0]    ys_q, ys_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             tick;

  sample_tick_gen #(
    .Period (SAMPLE_PERIOD)
  ) u_tick (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sclk_d  = 1'b0;
    shx_d   = shx_q;
    shy_d   = shy_q;
    xs_d    = xs_q;
    ys_d    = ys_q;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CONV;
          cnt_d   = '0;
        end
      end
      CONV: begin
        if (cnt_q == ConvLast) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        sclk_d = sclk_q;
        cnt_d  = cnt_q + 1'b1;
        if (half_q == HalfLast) begin
          half_d = '0;
          sclk_d = ~sclk_q;
          // Sample on the edge that raises SCLK, i.e. with the data the ADC held while low.
          if (!sclk_q) begin
            shx_d = {shx_q[DW-2:0], adc_sdo_x};
            shy_d = {shy_q[DW-2:0], adc_sdo_y};
          end
        end else begin
          half_d = half_q + 1'b1;
        end
        // Last capture happens CLK_DIV cycles before the end, so shx_q is complete here.
        if (cnt_q == ShiftLast) begin
          state_d = DONE;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          xs_d    = shx_q ^ MsbMask;
          ys_d    = shy_q ^ MsbMask;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Control pins are registered from the next state so they line up with the state register.
    cnv_d   = (state_d == CONV);
    cs_n_d  = (state_d != SHIFT);
    valid_d = (state_d == DONE);

    // A tick outside IDLE is dropped; flag it, and let a fresh event beat a simultaneous clear.
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      sclk_q    <= 1'b0;
      cnv_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      shx_q     <= '0;
      shy_q     <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      sclk_q    <= sclk_d;
      cnv_q     <= cnv_d;
      cs_n_q    <= cs_n_d;
      shx_q     <= shx_d;
      shy_q     <= shy_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_cnv      = cnv_q;
  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign xant_sample  = xs_q;
  assign yant_sample  = ys_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_dual_spi_if.sv
// Bench for adc_dual_spi_if: instance A uses defaults, instance B uses SAMPLE_PERIOD=70 and
// OFFSET_BINARY=0. Each has a serial ADC model fed from a word queue, and a scoreboard of
// expected samples and strobe cycles checked by a monitor on every sample_valid.
module tb_adc_dual_spi_if;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instance A signals
  logic        rst_a, en_a, cnv_a, csn_a, sclk_a, sx_a, sy_a, v_a, ov_a, ovc_a;
  logic [15:0] x_a, y_a;
  // Instance B signals
  logic        rst_b, en_b, cnv_b, csn_b, sclk_b, sx_b, sy_b, v_b, ov_b, ovc_b;
  logic [15:0] x_b, y_b;

  adc_dual_spi_if dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .enable       (en_a),
    .adc_cnv      (cnv_a),
    .adc_cs_n     (csn_a),
    .adc_sclk     (sclk_a),
    .adc_sdo_x    (sx_a),
    .adc_sdo_y    (sy_a),
    .xant_sample  (x_a),
    .yant_sample  (y_a),
    .sample_valid (v_a),
    .overrun      (ov_a),
    .overrun_clr  (ovc_a)
  );

  adc_dual_spi_if #(
    .SAMPLE_PERIOD (70),
    .OFFSET_BINARY (0)
  ) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .enable       (en_b),
    .adc_cnv      (cnv_b),
    .adc_cs_n     (csn_b),
    .adc_sclk     (sclk_b),
    .adc_sdo_x    (sx_b),
    .adc_sdo_y    (sy_b),
    .xant_sample  (x_b),
    .yant_sample  (y_b),
    .sample_valid (v_b),
    .overrun      (ov_b),
    .overrun_clr  (ovc_b)
  );

  // ADC models: word = {x, y}; MSB presented at CS_N fall, next bit after each SCLK rise.
  logic [31:0] wq_a[$], wq_b[$];
  logic [31:0] mw_a = '0, mw_b = '0;
  int          mb_a = 0, mb_b = 0;

  always @(negedge csn_a) begin
    mw_a = 32'h0;
    if (wq_a.size() > 0) mw_a = wq_a.pop_front();
    mb_a = 15;
    sx_a = mw_a[31];
    sy_a = mw_a[15];
  end
  always @(posedge sclk_a) begin
    if (!csn_a && mb_a > 0) begin
      mb_a--;
      sx_a = mw_a[16+mb_a];
      sy_a = mw_a[mb_a];
    end
  end

  always @(negedge csn_b) begin
    mw_b = 32'h0;
    if (wq_b.size() > 0) mw_b = wq_b.pop_front();
    mb_b = 15;
    sx_b = mw_b[31];
    sy_b = mw_b[15];
  end
  always @(posedge sclk_b) begin
    if (!csn_b && mb_b > 0) begin
      mb_b--;
      sx_b = mw_b[16+mb_b];
      sy_b = mw_b[mb_b];
    end
  end

  // Scoreboards and monitors
  exp_t exp_a[$], exp_b[$];
  exp_t e_a, e_b;
  int   cnv_len_a = 0, edges_a = 0, cnv_pulses_a = 0;
  logic cnv_prev_a = 1'b0;

  always @(posedge sclk_a) if (!csn_a) edges_a++;

  always @(negedge clk) begin
    if (cnv_a && !cnv_prev_a) begin
      cnv_len_a = 1;
      edges_a   = 0;
      cnv_pulses_a++;
    end else if (cnv_a) begin
      cnv_len_a++;
    end
    cnv_prev_a = cnv_a;
    if (v_a) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_valid", {31'd0, v_a}, 32'd0);
      end else begin
        e_a = exp_a.pop_front();
        check("a_xant", {16'd0, x_a}, {16'd0, e_a.x});
        check("a_yant", {16'd0, y_a}, {16'd0, e_a.y});
        check("a_valid_cycle", cyc, e_a.t);
        check("a_cnv_cycles", cnv_len_a, 32'd4);
        check("a_sclk_rises", edges_a, 32'd16);
      end
    end
  end

  always @(negedge clk) begin
    if (v_b) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_valid", {31'd0, v_b}, 32'd0);
      end else begin
        e_b = exp_b.pop_front();
        check("b_xant", {16'd0, x_b}, {16'd0, e_b.x});
        check("b_yant", {16'd0, y_b}, {16'd0, e_b.y});
        check("b_valid_cycle", cyc, e_b.t);
      end
    end
  end

  int          t_en, t2, tb;
  logic [15:0] vx, vy;

  initial begin
    rst_a = 1'b1; en_a = 1'b0; ovc_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; ovc_b = 1'b0;
    sx_a = 1'b0; sy_a = 1'b0; sx_b = 1'b0; sy_b = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cnv", {31'd0, cnv_a}, 32'd0);
    check("rst_cs_n", {31'd0, csn_a}, 32'd1);
    check("rst_sclk", {31'd0, sclk_a}, 32'd0);
    check("rst_xant", {16'd0, x_a}, 32'd0);
    check("rst_yant", {16'd0, y_a}, 32'd0);
    check("rst_valid", {31'd0, v_a}, 32'd0);
    check("rst_overrun", {31'd0, ov_a}, 32'd0);
    rst_a = 1'b0;
    @(negedge clk);

    // Single conversion then a ramp of 10, free running at 100 cycles.
    wq_a.push_back({16'h8123, 16'h7FFF});
    for (int n = 0; n < 10; n++) wq_a.push_back({16'h8000 + 16'(n), 16'h7FFF - 16'(n)});
    en_a = 1'b1;
    t_en = cyc;
    exp_a.push_back('{16'h0123, 16'hFFFF, t_en + 168});
    for (int n = 0; n < 10; n++) begin
      vx = 16'(n);
      vy = 16'hFFFF - 16'(n);
      exp_a.push_back('{vx, vy, t_en + 268 + 100 * n});
    end

    // Conversion 11: drop enable at bit 8 of its shift phase.
    wq_a.push_back({16'hA5A5, 16'h5A5A});
    exp_a.push_back('{16'h25A5, 16'hDA5A, t_en + 1268});
    repeat (t_en + 1236 - cyc) @(negedge clk);
    check("a_in_shift_at_drop", {31'd0, csn_a}, 32'd0);
    en_a = 1'b0;
    repeat (300) @(negedge clk);
    check("a_cnv_pulses_after_drop", cnv_pulses_a, 32'd12);
    check("a_no_overrun", {31'd0, ov_a}, 32'd0);
    check("a_scoreboard_drained", exp_a.size(), 32'd0);

    // Reset at bit 5 of a shift: aborted word is consumed but never strobed.
    wq_a.push_back({16'h1111, 16'h2222});
    wq_a.push_back({16'hC000, 16'h4000});
    en_a = 1'b1;
    t2 = cyc;
    exp_a.push_back('{16'h4000, 16'hC000, t2 + 293});
    repeat (124) @(negedge clk);
    check("a_in_shift_at_rst", {31'd0, csn_a}, 32'd0);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_rst_cs_n", {31'd0, csn_a}, 32'd1);
    check("a_rst_sclk", {31'd0, sclk_a}, 32'd0);
    check("a_rst_cnv", {31'd0, cnv_a}, 32'd0);
    check("a_rst_xant", {16'd0, x_a}, 32'd0);
    check("a_rst_yant", {16'd0, y_a}, 32'd0);
    check("a_rst_valid", {31'd0, v_a}, 32'd0);
    rst_a = 1'b0;
    repeat (185) @(negedge clk);
    en_a = 1'b0;
    repeat (100) @(negedge clk);
    check("a_rst_scoreboard_drained", exp_a.size(), 32'd0);
    check("a_cnv_pulses_total", cnv_pulses_a, 32'd14);

    // Instance B: two's-complement passthrough, minimum period, forced overrun ticks.
    rst_b = 1'b0;
    @(negedge clk);
    wq_b.push_back({16'h8000, 16'h0001});
    wq_b.push_back({16'h1357, 16'hFEDC});
    wq_b.push_back({16'h0F0F, 16'hF0F0});
    en_b = 1'b1;
    tb = cyc;
    exp_b.push_back('{16'h8000, 16'h0001, tb + 138});
    exp_b.push_back('{16'h1357, 16'hFEDC, tb + 208});
    exp_b.push_back('{16'h0F0F, 16'hF0F0, tb + 278});
    check("b_overrun_init", {31'd0, ov_b}, 32'd0);

    repeat (160) @(negedge clk);
    check("b_in_shift", {31'd0, csn_b}, 32'd0);
    force dut_b.tick = 1'b1;
    @(negedge clk);
    release dut_b.tick;
    check("b_overrun_set", {31'd0, ov_b}, 32'd1);

    repeat (59) @(negedge clk);
    ovc_b = 1'b1;
    @(negedge clk);
    ovc_b = 1'b0;
    check("b_overrun_cleared", {31'd0, ov_b}, 32'd0);

    repeat (9) @(negedge clk);
    force dut_b.tick = 1'b1;
    ovc_b = 1'b1;
    @(negedge clk);
    release dut_b.tick;
    ovc_b = 1'b0;
    check("b_set_beats_clear", {31'd0, ov_b}, 32'd1);

    repeat (19) @(negedge clk);
    en_b = 1'b0;
    repeat (80) @(negedge clk);
    check("b_overrun_sticky", {31'd0, ov_b}, 32'd1);
    check("b_scoreboard_drained", exp_b.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
